// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types for the two-stage pipeline.
//   word_t        : 32-bit machine word
//   RV32I_NOP     : addi x0,x0,0, used to fill the IF/EX latch on bubbles and flushes
//   fetch_state_t : fetch FSM states
//   ifex_t        : contents of the IF/EX pipeline latch
package rv32i_types_pkg;

   typedef logic [31:0] word_t;

   localparam word_t RV32I_NOP = 32'h0000_0013;

   typedef enum logic {
      FETCH = 1'b0,
      PEND  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic  valid;
      word_t instr;
      word_t pc;
      word_t pc4;
      logic  fault;
      logic  mal;
   } ifex_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Status/control link between the fetch stage and the hazard unit.
//   fetch modport  : fetch stage side (takes control, reports status)
//   hazard modport : hazard unit side
//   pc_en, npc_sel, if_ex_stall, if_ex_flush : hazard -> fetch
//   i_ram_busy, fault_insn, mal_insn         : fetch -> hazard
interface hazard_unit_if;

   logic pc_en;
   logic npc_sel;
   logic if_ex_stall;
   logic if_ex_flush;
   logic i_ram_busy;
   logic fault_insn;
   logic mal_insn;

   modport fetch (
      input  pc_en, npc_sel, if_ex_stall, if_ex_flush,
      output i_ram_busy, fault_insn, mal_insn
   );

   modport hazard (
      output pc_en, npc_sel, if_ex_stall, if_ex_flush,
      input  i_ram_busy, fault_insn, mal_insn
   );

endinterface

// File: rtl/tspp_pc_gen.sv
// PC register, pending-redirect register and fetch FSM.
//   in : CLK, nRST, pc_en, npc_sel, insert_pc, priv_pc, brj_addr
//   out: pc (current fetch address), state, redirect (redirect requested this cycle)
//
// state | meaning
// FETCH | no redirect queued; pc advances or redirects on pc_en
// PEND  | redirect queued in pend_pc, applied on the next pc_en
module tspp_pc_gen
   import rv32i_types_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0200
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         pc_en,
   input  logic         npc_sel,
   input  logic         insert_pc,
   input  word_t        priv_pc,
   input  word_t        brj_addr,
   output word_t        pc,
   output fetch_state_t state,
   output logic         redirect
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pend_pc_q, pend_pc_d;
   word_t        target;

   // Trap/return outranks a branch resolved in the same cycle.
   assign redirect = insert_pc | npc_sel;
   assign target   = insert_pc ? priv_pc : brj_addr;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         FETCH: begin
            if (pc_en) begin
               pc_d = redirect ? target : pc_q + 32'd4;
            end else if (redirect) begin
               pend_pc_d = target;
               state_d   = PEND;
            end
         end
         PEND: begin
            if (pc_en) begin
               pc_d    = redirect ? target : pend_pc_q;
               state_d = FETCH;
            end else if (redirect) begin
               pend_pc_d = target;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign pc    = pc_q;
   assign state = state_q;

endmodule

// File: rtl/tspp_fetch_stage.sv
// Fetch stage: issues instruction reads at the PC, reports status to the hazard
// unit and drives the IF/EX pipeline latch.
//   CLK, nRST                       : clock / async active-low reset
//   hz (hazard_unit_if.fetch)       : pc_en, npc_sel, stall/flush in; busy/fault/mal out
//   insert_pc, priv_pc, brj_addr    : redirect requests and targets
//   iaddr, iren, irdata, i_busy, i_err : instruction memory port
//   ifex_*                          : IF/EX latch contents
module tspp_fetch_stage
   import rv32i_types_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0200,
   parameter word_t NOP_INSN = RV32I_NOP
) (
   input  logic                 CLK,
   input  logic                 nRST,
   hazard_unit_if.fetch         hz,
   input  logic                 insert_pc,
   input  word_t                priv_pc,
   input  word_t                brj_addr,
   output word_t                iaddr,
   output logic                 iren,
   input  word_t                irdata,
   input  logic                 i_busy,
   input  logic                 i_err,
   output logic                 ifex_valid,
   output word_t                ifex_instr,
   output word_t                ifex_pc,
   output word_t                ifex_pc4,
   output logic                 ifex_fault,
   output logic                 ifex_mal
);

   word_t        pc;
   fetch_state_t state;
   logic         redirect;
   logic         mal;
   logic         fault;
   logic         done;
   ifex_t        ifex_q, ifex_d;

   tspp_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
      .CLK       (CLK),
      .nRST      (nRST),
      .pc_en     (hz.pc_en),
      .npc_sel   (hz.npc_sel),
      .insert_pc (insert_pc),
      .priv_pc   (priv_pc),
      .brj_addr  (brj_addr),
      .pc        (pc),
      .state     (state),
      .redirect  (redirect)
   );

   // A misaligned PC never reaches memory; it completes at once so the fault
   // can travel down the pipe as an instruction.
   assign mal   = (pc[1:0] != 2'b00);
   assign iren  = !mal;
   assign iaddr = pc;
   assign fault = iren & !i_busy & i_err;
   assign done  = mal | (iren & !i_busy);

   assign hz.i_ram_busy = iren & i_busy;
   assign hz.fault_insn = fault;
   assign hz.mal_insn   = mal;

   always_comb begin
      ifex_d = ifex_q;
      if (hz.if_ex_flush) begin
         ifex_d.valid = 1'b0;
         ifex_d.instr = NOP_INSN;
         ifex_d.fault = 1'b0;
         ifex_d.mal   = 1'b0;
      end else if (hz.if_ex_stall) begin
         ifex_d = ifex_q;
      end else if (done && (state == FETCH) && !redirect) begin
         ifex_d.valid = 1'b1;
         ifex_d.instr = irdata;
         ifex_d.pc    = pc;
         ifex_d.pc4   = pc + 32'd4;
         ifex_d.fault = fault;
         ifex_d.mal   = mal;
      end else begin
         // Wrong-path or incomplete fetch: insert a bubble.
         ifex_d.valid = 1'b0;
         ifex_d.instr = NOP_INSN;
         ifex_d.fault = 1'b0;
         ifex_d.mal   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ifex_q <= '{valid: 1'b0, instr: NOP_INSN, pc: '0, pc4: '0, fault: 1'b0, mal: 1'b0};
      end else begin
         ifex_q <= ifex_d;
      end
   end

   assign ifex_valid = ifex_q.valid;
   assign ifex_instr = ifex_q.instr;
   assign ifex_pc    = ifex_q.pc;
   assign ifex_pc4   = ifex_q.pc4;
   assign ifex_fault = ifex_q.fault;
   assign ifex_mal   = ifex_q.mal;

endmodule

// File: tb/tb_tspp_fetch_stage.sv
// Bench for tspp_fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_tspp_fetch_stage;
   import rv32i_types_pkg::*;

   localparam word_t RST_PC = 32'h0000_0200;
   localparam word_t NOP    = 32'h0000_0013;

   logic  CLK = 1'b0;
   logic  nRST = 1'b0;
   logic  insert_pc = 1'b0;
   word_t priv_pc = '0;
   word_t brj_addr = '0;
   word_t iaddr;
   logic  iren;
   word_t irdata = '0;
   logic  i_busy = 1'b0;
   logic  i_err = 1'b0;
   logic  ifex_valid;
   word_t ifex_instr;
   word_t ifex_pc;
   word_t ifex_pc4;
   logic  ifex_fault;
   logic  ifex_mal;

   hazard_unit_if hz_if ();

   tspp_fetch_stage dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .hz         (hz_if.fetch),
      .insert_pc  (insert_pc),
      .priv_pc    (priv_pc),
      .brj_addr   (brj_addr),
      .iaddr      (iaddr),
      .iren       (iren),
      .irdata     (irdata),
      .i_busy     (i_busy),
      .i_err      (i_err),
      .ifex_valid (ifex_valid),
      .ifex_instr (ifex_instr),
      .ifex_pc    (ifex_pc),
      .ifex_pc4   (ifex_pc4),
      .ifex_fault (ifex_fault),
      .ifex_mal   (ifex_mal)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Reference model: current PC, an optional queued redirect, and the latch.
   word_t m_pc;
   bit    m_pending;
   word_t m_pend_pc;
   bit    m_valid;
   word_t m_instr;
   word_t m_ipc;
   bit    m_fault;
   bit    m_mal;

   task automatic model_reset();
      m_pc      = RST_PC;
      m_pending = 0;
      m_pend_pc = '0;
      m_valid   = 0;
      m_instr   = NOP;
      m_ipc     = '0;
      m_fault   = 0;
      m_mal     = 0;
   endtask

   // One clock: drive inputs, check combinational outputs, advance model, check latch.
   task automatic step(input bit pe, input bit ns, input bit ip, input word_t brj,
                       input word_t priv, input bit busy, input bit err, input word_t rd,
                       input bit st, input bit fl);
      bit    mal_e, iren_e, done_e, fault_e, redir;
      word_t tgt;
      @(negedge CLK);
      hz_if.pc_en       = pe;
      hz_if.npc_sel     = ns;
      hz_if.if_ex_stall = st;
      hz_if.if_ex_flush = fl;
      insert_pc = ip;
      brj_addr  = brj;
      priv_pc   = priv;
      i_busy    = busy;
      i_err     = err;
      irdata    = rd;
      #1;
      mal_e   = (m_pc % 4) != 0;
      iren_e  = !mal_e;
      done_e  = mal_e || !busy;
      fault_e = iren_e && !busy && err;
      chk("iaddr", iaddr, m_pc);
      chk("iren", {31'b0, iren}, {31'b0, iren_e});
      chk("i_ram_busy", {31'b0, hz_if.i_ram_busy}, {31'b0, iren_e && busy});
      chk("fault_insn", {31'b0, hz_if.fault_insn}, {31'b0, fault_e});
      chk("mal_insn", {31'b0, hz_if.mal_insn}, {31'b0, mal_e});

      redir = ip || ns;
      tgt   = ip ? priv : brj;
      if (fl) begin
         m_valid = 0; m_instr = NOP; m_fault = 0; m_mal = 0;
      end else if (st) begin
         // latch holds
      end else if (done_e && !m_pending && !redir) begin
         m_valid = 1; m_instr = rd; m_ipc = m_pc; m_fault = fault_e; m_mal = mal_e;
      end else begin
         m_valid = 0; m_instr = NOP;
      end

      if (pe) begin
         m_pc      = redir ? tgt : (m_pending ? m_pend_pc : m_pc + 32'd4);
         m_pending = 0;
      end else if (redir) begin
         m_pending = 1;
         m_pend_pc = tgt;
      end

      @(posedge CLK);
      #1;
      chk("iaddr_next", iaddr, m_pc);
      chk("ifex_valid", {31'b0, ifex_valid}, {31'b0, m_valid});
      chk("ifex_instr", ifex_instr, m_instr);
      if (m_valid) begin
         chk("ifex_pc", ifex_pc, m_ipc);
         chk("ifex_pc4", ifex_pc4, m_ipc + 32'd4);
         chk("ifex_fault", {31'b0, ifex_fault}, {31'b0, m_fault});
         chk("ifex_mal", {31'b0, ifex_mal}, {31'b0, m_mal});
      end
   endtask

   initial begin
      bit    pe, ns, ip, busy, err, st, fl;
      word_t brj, priv, rd;
      hz_if.pc_en = 0; hz_if.npc_sel = 0; hz_if.if_ex_stall = 0; hz_if.if_ex_flush = 0;
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      chk("rst_iaddr", iaddr, RST_PC);
      chk("rst_iren", {31'b0, iren}, 32'd1);
      chk("rst_valid", {31'b0, ifex_valid}, 32'd0);
      chk("rst_instr", ifex_instr, NOP);
      chk("rst_pc", ifex_pc, 32'd0);
      chk("rst_pc4", ifex_pc4, 32'd0);
      chk("rst_fault", {31'b0, ifex_fault}, 32'd0);
      chk("rst_mal", {31'b0, ifex_mal}, 32'd0);

      // Sequential fetch
      step(1, 0, 0, 0, 0, 0, 0, 32'hAAAA_0001, 0, 0);
      chk("t1_iaddr1", iaddr, 32'h204);
      chk("t1_ifex_pc", ifex_pc, 32'h200);
      step(1, 0, 0, 0, 0, 0, 0, 32'hAAAA_0002, 0, 0);
      chk("t1_iaddr2", iaddr, 32'h208);

      // Busy memory holds the address; latch fills with bubbles
      repeat (3) step(0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
      chk("t2_hold", iaddr, 32'h208);
      step(1, 0, 0, 0, 0, 0, 0, 32'hCAFE_0003, 0, 0);
      chk("t2_instr", ifex_instr, 32'hCAFE_0003);
      chk("t2_pc", ifex_pc, 32'h208);

      // Redirect during a busy fetch is queued; the completing word is dropped
      step(0, 1, 0, 32'h400, 0, 1, 0, 32'h1111_1111, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 32'h2222_2222, 0, 0);
      chk("t3_iaddr", iaddr, 32'h400);
      chk("t3_drop", {31'b0, ifex_valid}, 32'd0);

      // Trap redirect beats branch redirect
      step(1, 1, 1, 32'h400, 32'h100, 0, 0, 32'h3333_3333, 0, 0);
      chk("t4_iaddr", iaddr, 32'h100);

      // Misaligned target, then a bus error
      step(1, 1, 0, 32'h402, 0, 0, 0, 32'h4444_4444, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 32'h5555_5555, 0, 0);
      chk("t5_mal", {31'b0, ifex_mal}, 32'd1);
      chk("t5_mal_pc", ifex_pc, 32'h402);
      step(1, 1, 0, 32'h500, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 32'h6666_6666, 0, 0);
      chk("t5_fault", {31'b0, ifex_fault}, 32'd1);

      // PC wrap at the top of the address space
      step(1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 32'h7777_7777, 0, 0);
      chk("wrap", iaddr, 32'h0);

      // Flush beats stall
      step(1, 0, 0, 0, 0, 0, 0, 32'h8888_8888, 1, 1);
      chk("t6_flush_instr", ifex_instr, NOP);

      // Reset in the middle of a busy fetch
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      model_reset();
      chk("t6_rst_iaddr", iaddr, RST_PC);
      chk("t6_rst_valid", {31'b0, ifex_valid}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0, 32'h9999_9999, 0, 0);
      chk("t6_first", ifex_pc, RST_PC);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         pe   = ($urandom % 4) != 0;
         ns   = ($urandom % 6) == 0;
         ip   = ($urandom % 10) == 0;
         brj  = {$urandom, 2'b00} >> 2;
         brj  = {brj[29:0], 2'b00};
         if (($urandom % 8) == 0) brj[1:0] = 2'($urandom);
         if (($urandom % 25) == 0) brj = 32'hFFFF_FFF8;
         priv = {$urandom} & 32'hFFFF_FFFC;
         busy = ($urandom % 3) == 0;
         err  = ($urandom % 8) == 0;
         rd   = $urandom;
         st   = ($urandom % 8) == 0;
         fl   = ($urandom % 10) == 0;
         step(pe, ns, ip, brj, priv, busy, err, rd, st, fl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
